// File: rtl/cipher_stream_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : cipher_stream_tx_if - valid/ready word stream with byte keep and last flag
// Revision : 1.0 - initial release
// ============================================================================
interface cipher_stream_tx_if #(
  parameter int WORD_W = 32
) ();
  logic [WORD_W-1:0]   word;
  logic [WORD_W/8-1:0] keep;
  logic                valid;
  logic                ready;
  logic                last;

  modport master (output word, keep, valid, last, input ready);
  modport slave  (input word, keep, valid, last, output ready);
endinterface
`default_nettype wire

// File: rtl/cipher_stream_tx.sv
`default_nettype none
// ============================================================================
// Module   : cipher_stream_tx - serialises 128-bit ciphertext blocks into WORD_W-bit words
//            (CIPHER_TX_DBUF_EN adds a holding buffer for bubble-free back-to-back blocks)
// Revision : 1.0 - initial release
// ============================================================================
module cipher_stream_tx #(
  parameter int WORD_W = 32
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [127:0] cipher_i,
  input  logic         last_i,
  input  logic [4:0]   nbytes_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         overrun_o,
  cipher_stream_tx_if.master tx
);
  localparam int N_WORDS = 128 / WORD_W;
  localparam int BPW     = WORD_W / 8;
  localparam int SH      = $clog2(BPW);
  localparam int IW      = $clog2(N_WORDS);
  localparam int CW      = IW + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [4:0]     w_nb;
  logic [5:0]     w_nb_round;
  logic [CW-1:0]  w_cnt;
  logic [4:0]     w_rem;
  logic [BPW-1:0] w_keep;
  logic [127:0]   w_data;

  // Decode the incoming block: clamp the byte count, zero bytes past it, derive word count and final keep.
  always_comb begin
    w_nb = 5'd16;
    if (last_i && (nbytes_i < 5'd16)) w_nb = nbytes_i;
    w_nb_round = {1'b0, w_nb} + 6'(BPW - 1);
    w_cnt      = CW'(w_nb_round >> SH);
    w_rem      = w_nb & 5'(BPW - 1);
    w_keep     = '1;
    if (w_rem != 5'd0) begin
      for (int j = 0; j < BPW; j++) w_keep[j] = (5'(j) < w_rem);
    end
    for (int b = 0; b < 16; b++) begin
      w_data[b*8 +: 8] = (5'(b) < w_nb) ? cipher_i[b*8 +: 8] : 8'h00;
    end
  end

  logic [0:0]     r_state;
  logic [127:0]   r_buf;
  logic [CW-1:0]  r_cnt;
  logic [IW-1:0]  r_idx;
  logic           r_last;
  logic [BPW-1:0] r_lkeep;
  logic           r_done;
  logic [1:0]     r_owed;
  logic           r_overrun;

  logic [N_WORDS-1:0][WORD_W-1:0] w_words;
  logic       w_send;
  logic       w_on_last;
  logic       w_hs;
  logic       w_final;
  logic       w_accept;
  logic       w_zero;
  logic       w_take;
  logic [2:0] w_owed_tot;

`ifdef CIPHER_TX_DBUF_EN
  logic [127:0]   r_hbuf;
  logic [CW-1:0]  r_hcnt;
  logic           r_hlast;
  logic [BPW-1:0] r_hkeep;
  logic           r_hfull;

  assign busy_o = w_send && r_hfull;
`else
  assign busy_o = w_send;
`endif

  assign w_send     = (r_state == S_SEND);
  assign w_words    = r_buf;
  assign w_on_last  = ({1'b0, r_idx} == (r_cnt - CW'(1)));
  assign w_hs       = w_send && tx.ready;
  assign w_final    = w_hs && w_on_last;
  assign w_accept   = load_i && !busy_o;
  assign w_zero     = w_accept && (w_cnt == '0);
  assign w_take     = w_accept && !w_zero;
  // A zero-length block can complete in the same cycle as a streamed one; owe the extra pulse.
  assign w_owed_tot = {1'b0, r_owed} + {2'b00, w_final} + {2'b00, w_zero};

  assign tx.valid = w_send;
  assign tx.word  = w_send ? w_words[r_idx] : '0;
  assign tx.keep  = !w_send ? '0 : ((r_last && w_on_last) ? r_lkeep : '1);
  assign tx.last  = w_send && r_last && w_on_last;
  assign done_o    = r_done;
  assign overrun_o = r_overrun;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state   <= S_IDLE;
      r_buf     <= '0;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_last    <= 1'b0;
      r_lkeep   <= '0;
      r_done    <= 1'b0;
      r_owed    <= 2'd0;
      r_overrun <= 1'b0;
`ifdef CIPHER_TX_DBUF_EN
      r_hbuf    <= '0;
      r_hcnt    <= '0;
      r_hlast   <= 1'b0;
      r_hkeep   <= '0;
      r_hfull   <= 1'b0;
`endif
    end else begin
      if (load_i && busy_o) r_overrun <= 1'b1;
      r_done <= (w_owed_tot != 3'd0);
      r_owed <= (w_owed_tot != 3'd0) ? 2'(w_owed_tot - 3'd1) : 2'd0;
      if (w_hs && !w_final) r_idx <= r_idx + IW'(1);
`ifdef CIPHER_TX_DBUF_EN
      if (w_final && r_hfull) begin
        r_buf   <= r_hbuf;
        r_cnt   <= r_hcnt;
        r_last  <= r_hlast;
        r_lkeep <= r_hkeep;
        r_idx   <= '0;
        r_hfull <= 1'b0;
      end else if (w_take && (!w_send || w_final)) begin
        r_buf   <= w_data;
        r_cnt   <= w_cnt;
        r_last  <= last_i;
        r_lkeep <= w_keep;
        r_idx   <= '0;
        r_state <= S_SEND;
      end else if (w_final) begin
        r_state <= S_IDLE;
      end
      if (w_take && w_send && !w_final) begin
        r_hbuf  <= w_data;
        r_hcnt  <= w_cnt;
        r_hlast <= last_i;
        r_hkeep <= w_keep;
        r_hfull <= 1'b1;
      end
`else
      if (w_take) begin
        r_buf   <= w_data;
        r_cnt   <= w_cnt;
        r_last  <= last_i;
        r_lkeep <= w_keep;
        r_idx   <= '0;
        r_state <= S_SEND;
      end else if (w_final) begin
        r_state <= S_IDLE;
      end
`endif
    end
  end
endmodule
`default_nettype wire
